// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth signed multiplier.
// Each multiplier bit takes two cycles: an add/subtract phase, then an
// arithmetic right shift of {A,Q,Q-1}. The product is registered on the
// final shift and held until the next multiply completes.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t           state;
  // A and M carry one extra sign bit so that M = -2^(WIDTH-1) cannot overflow
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [CW-1:0]    cnt_dec;

  // Arithmetic right shift of {A,Q}: A msb replicated, A[0] into Q msb
  assign a_sh    = {a[WIDTH], a[WIDTH:1]};
  assign q_sh    = {a[0], q[WIDTH-1:1]};
  assign cnt_dec = cnt - 1'b1;

  // Status flags decode straight from the state register
  assign ready = (state == S_IDLE);
  assign busy  = (state == S_ADD) || (state == S_SHIFT);
  assign done  = (state == S_DONE);

  // Control FSM and datapath registers; reset wins over any in-flight multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q1      <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a     <= '0;
            q     <= multiplier;
            q1    <= 1'b0;
            m     <= {multiplicand[WIDTH-1], multiplicand};
            cnt   <= CW'(WIDTH);
            state <= S_ADD;
          end
        end
        S_ADD: begin
          case ({q[0], q1})
            2'b10:   a <= a - m;
            2'b01:   a <= a + m;
            default: a <= a;
          endcase
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          a   <= a_sh;
          q   <= q_sh;
          q1  <= q[0];
          cnt <= cnt_dec;
          if (cnt_dec == '0) begin
            // The product is the post-shift {A,Q} with the extra sign bit dropped
            product <= {a_sh[WIDTH-1:0], q_sh};
            state   <= S_DONE;
          end else begin
            state <= S_ADD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed checks of booth_mul_seq at WIDTH=8 plus an
// exhaustive WIDTH=4 sweep on a second instance.
module tb_booth_mul_seq;

  logic        clk;
  logic        rst, start;
  logic [7:0]  multiplicand, multiplier;
  logic        ready, busy, done;
  logic [15:0] product;

  logic        rst4, start4;
  logic [3:0]  mc4, mp4;
  logic        ready4, busy4, done4;
  logic [7:0]  product4;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  booth_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4),
    .multiplicand(mc4), .multiplier(mp4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 multiply from IDLE and wait (bounded) for done
  task automatic run8(input logic [7:0] mv, input logic [7:0] qv,
                      output int lat, output logic to);
    multiplicand = mv;
    multiplier   = qv;
    start        = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    to = !done;
  endtask

  // Same for the WIDTH=4 instance
  task automatic run4(input logic [3:0] mv, input logic [3:0] qv,
                      output int lat, output logic to);
    mc4    = mv;
    mp4    = qv;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat    = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    to = !done4;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; start = 1'b0; start4 = 1'b0;
    multiplicand = '0; multiplier = '0; mc4 = '0; mp4 = '0;
    tick();
    tick();
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/done=%b expected 100", {ready, busy, done});
    end
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product: got %h expected 0000", product);
    end
    checks++;
    if ({ready4, busy4, done4, product4} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL reset_w4: got %b/%h expected 100/00", {ready4, busy4, done4}, product4);
    end
    rst = 1'b0; rst4 = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, busy_n, rlo_n;
    multiplicand = 8'd3;
    multiplier   = 8'd5;
    start        = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 0;
    busy_n = 0;
    rlo_n  = 0;
    forever begin
      if (busy)   busy_n++;
      if (!ready) rlo_n++;
      if (done || cyc >= 40) break;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 16 || !done) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (done=%b) expected 16", cyc, done);
    end
    checks++;
    if (product !== 16'h000F) begin
      errors++;
      $display("FAIL basic_product: got %h expected 000f", product);
    end
    checks++;
    if (busy_n !== 16) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 16", busy_n);
    end
    checks++;
    if (rlo_n !== 17) begin
      errors++;
      $display("FAIL basic_ready_low: got %0d expected 17", rlo_n);
    end
    tick();
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL basic_after_done: got %b expected 100", {ready, busy, done});
    end
  endtask

  task automatic test_signs();
    logic [7:0]  mt [4];
    logic [7:0]  qt [4];
    logic [15:0] pt [4];
    int          lat;
    logic        to;
    mt = '{8'hFD, 8'h80, 8'h7F, 8'h00};
    qt = '{8'h05, 8'h80, 8'h80, 8'hFF};
    pt = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      run8(mt[i], qt[i], lat, to);
      checks++;
      if (to || lat !== 16) begin
        errors++;
        $display("FAIL sign%0d_latency: got %0d timeout=%b expected 16", i, lat, to);
      end
      checks++;
      if (product !== pt[i]) begin
        errors++;
        $display("FAIL sign%0d_product: got %h expected %h", i, product, pt[i]);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL sign%0d_pulse: done still %b one cycle later expected 0", i, done);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dn;
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    multiplicand = 8'd2;
    multiplier   = 8'd2;
    start        = 1'b1;
    tick();
    start = 1'b0;
    dn    = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL ignored_done_count: got %0d expected 1", dn);
    end
    checks++;
    if (product !== 16'h003F) begin
      errors++;
      $display("FAIL ignored_product: got %h expected 003f", product);
    end
  endtask

  task automatic test_mid_reset();
    int   dn, lat;
    logic to;
    multiplicand = 8'd10;
    multiplier   = 8'd10;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_state: got flags=%b product=%h expected 100/0000",
               {ready, busy, done}, product);
    end
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d done pulses expected 0", dn);
    end
    run8(8'd4, 8'hFE, lat, to);
    checks++;
    if (to || product !== 16'hFFF8) begin
      errors++;
      $display("FAIL midrst_next_product: got %h timeout=%b expected fff8", product, to);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t [4];
    int nd, bad;
    multiplicand = 8'd6;
    multiplier   = 8'hF9;
    start        = 1'b1;
    nd  = 0;
    bad = 0;
    for (int c = 1; c <= 120 && nd < 4; c++) begin
      tick();
      if (nd > 0 && product !== 16'hFFD6) bad++;
      if (done) begin
        t[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    checks++;
    if (nd !== 4) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d done pulses expected 4", nd);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (t[i] - t[i-1] !== 18) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d cycles expected 18", i, t[i] - t[i-1]);
        end
      end
    end
    checks++;
    if (bad !== 0 || product !== 16'hFFD6) begin
      errors++;
      $display("FAIL b2b_product: %0d unstable cycles, product=%h expected ffd6", bad, product);
    end
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_sweep_w4();
    int         lat, p, bad;
    logic       to;
    logic [3:0] mv, qv;
    logic [7:0] exp8;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        mv   = 4'(i);
        qv   = 4'(j);
        p    = $signed(mv) * $signed(qv);
        exp8 = p[7:0];
        run4(mv, qv, lat, to);
        checks++;
        if (to || lat !== 8 || product4 !== exp8) begin
          errors++;
          bad++;
          if (bad <= 8)
            $display("FAIL sweep_w4 %0d*%0d: got %h lat=%0d timeout=%b expected %h lat=8",
                     $signed(mv), $signed(qv), product4, lat, to, exp8);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_sweep_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
